// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    localparam int unsigned LEN_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

endpackage

// File: rtl/prog_word_asm.sv
// Byte-to-word assembler: shifts bytes MSB-first and flags the last byte of each word.
module prog_word_asm
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word_c,
    output logic                  word_complete_c
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_WIDTH-1:0] word_q;
    logic [CW-1:0]         cnt;

    // Word as it stands once the incoming byte lands in the low lane.
    assign word_c          = DATA_WIDTH'({word_q, byte_in});
    assign word_complete_c = shift && (cnt == CW'(BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt    <= '0;
        end else if (clr) begin
            word_q <= '0;
            cnt    <= '0;
        end else if (shift) begin
            word_q <= word_c;
            cnt    <= word_complete_c ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into program memory while holding the CPU in reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0] wd,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    generate
        if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
            $error("prog_loader: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

    state_e                state;
    logic [15:0]           len;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH-1:0] addr;

    logic                  xfer_c;
    logic                  start_ok_c;
    logic                  asm_shift_c;
    logic [15:0]           len_c;
    logic                  len_ok_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic                  word_complete_c;

    assign xfer_c      = in_valid & in_ready;
    assign start_ok_c  = start && ((state == ST_IDLE) || (state == ST_ERR));
    assign asm_shift_c = xfer_c && (state == ST_DATA);

    // Full 16-bit length once the low byte arrives; checked at full width.
    assign len_c    = {len[15:8], in_data};
    assign len_ok_c = (len_c != 16'd0) && (32'(len_c) <= MAX_WORDS);

    prog_word_asm #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk             (clk),
        .rst             (rst),
        .clr             (start_ok_c),
        .shift           (asm_shift_c),
        .byte_in         (in_data),
        .word_c          (word_c),
        .word_complete_c (word_complete_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len       <= '0;
            remaining <= '0;
            addr      <= '0;
            in_ready  <= 1'b0;
            we        <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        state     <= ST_LEN_HI;
                        err       <= 1'b0;
                        addr      <= '0;
                        len       <= '0;
                        remaining <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        cpu_hold  <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer_c) begin
                        len   <= {in_data, len[7:0]};
                        state <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_c) begin
                        len <= len_c;
                        if (len_ok_c) begin
                            remaining <= (ADDR_WIDTH + 1)'(len_c);
                            state     <= ST_DATA;
                        end else begin
                            state    <= ST_ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer_c && word_complete_c) begin
                        state    <= ST_WRITE;
                        we       <= 1'b1;
                        wa       <= addr;
                        wd       <= word_c;
                        in_ready <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    addr      <= addr + ADDR_WIDTH'(1);
                    remaining <= remaining - (ADDR_WIDTH + 1)'(1);
                    if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                        state    <= ST_IDLE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= ST_DATA;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= err;
                end
            endcase
        end
    end

endmodule
